srio_nwrite_segmenter: RTL and testbench
========================================

// Module: srio_nwrite_segmenter
// PURPOSE
//  Downstream consumer of transDataLength in the SRIO TX path. Takes one write command (byte length minus one, base address)
//  plus a 64-bit payload stream. Splits the command into SRIO NWRITE segments: full 256B segments first, then one final
//  segment sized up to 8/16/32/64/128/256 B. Emits a per-segment header, then that segment's data beats, zero-padded to the segment size.
// PARAMETERS
//  ADDR_W   34  SRIO address width
//  DATA_W   64  payload width; fixed at 64 (8 bytes/beat, byte0 = [63:56])
//  LEN_W    20  command length width (bytes minus one)
// PORTS
//  clk          in   1       single clock domain
//  reset_n      in   1       synchronous, active-low reset
//  cmd_valid    in   1       command request
//  cmd_ready    out  1       high only in IDLE
//  cmd_len      in   LEN_W   bytes in transfer minus one
//  cmd_addr     in   ADDR_W  base address, 8B aligned
//  s_data       in   DATA_W  payload beat
//  s_valid      in   1       payload valid
//  s_ready      out  1       payload accept
//  seg_valid    out  1       segment header valid, held until seg_ready
//  seg_ready    in   1       header accept
//  seg_addr     out  ADDR_W  segment start address
//  seg_size     out  8       segment bytes minus one (7,15,31,63,127,255)
//  seg_last     out  1       header is final segment of command
//  m_data       out  DATA_W  segment data beat (registered)
//  m_valid      out  1       data valid, held until m_ready
//  m_ready      in   1       data accept
//  m_last       out  1       last beat of current segment
//  done         out  1       1-cycle pulse after final beat of command accepted
// BEHAVIOUR
//  Reset (reset_n=0 at clk edge): state=IDLE; cmd_ready=1; s_ready, seg_valid, m_valid, m_last, seg_last, done = 0;
//   seg_addr, seg_size, m_data = 0. A command in progress is discarded; no partial beats are emitted afterwards.
//  Command capture: cmd_valid&&cmd_ready in IDLE latches len and addr.
//   full_segs = len[19:8], fin_size = rounded(len[7:0]) per the 8/16/32/64/128/256 table,
//   real_beats_fin = len[7:3]+1, fin_beats = fin_size/8, pad_beats = fin_beats - real_beats_fin,
//   last_bytes = len[2:0]+1. Total segments = full_segs+1 (12-bit counter + 1; must not overflow at len=0xFFFFF).
//  States: IDLE -> HDR (on capture) -> DATA (seg_valid&&seg_ready) -> HDR (m_last beat accepted, segments remain)
//   | DONE (m_last beat accepted, final segment) -> IDLE next cycle with done=1 for that cycle.
//  HDR: seg_valid=1 the cycle after entry. seg_addr = base + 256*seg_index (ADDR_W wrap allowed).
//   seg_size = 255 for full segments, fin_size-1 for the final. seg_last=1 only on the final segment.
//  DATA: 1-entry registered output stage. s_ready = in_DATA && real beats remain in segment && (!m_valid || m_ready).
//   Accepted s_data appears on m_data the next cycle (latency 1).
//   In the last real beat of the command, bytes with index >= last_bytes are forced to 0.
//   After the real beats, pad_beats beats of all-zero data are generated with s_ready=0.
//   m_last is asserted on beat 32 of a full segment and on beat fin_beats of the final segment.
//  No header is issued while any data beat of the previous segment is pending. Header and data are never valid together.
//  Simultaneous m_valid/m_ready with a new s_valid: old beat leaves, new beat loads in the same cycle (no bubble).
//  s_valid is ignored outside DATA. Extra beats beyond ceil((len+1)/8) are never accepted.
// TESTING
//  1. len=0, addr=0x1000, s_data=0xAABBCCDD_EEFF0011 -> one header {0x1000, size=7, last=1};
//     one beat 0xAA00_0000_0000_0000, m_last=1, then done.
//  2. len=255, addr=0 -> one header size=255, last=1; 32 beats passed unmodified, no pad; m_last on beat 32.
//  3. len=299, addr=0x2000 -> headers {0x2000,255,0}, {0x2100,63,1}. 38 input beats; beat 38 keeps 4 bytes, low 4 zeroed.
//     Final segment = 6 real beats + 2 zero beats.
//  4. len=299 with random seg_ready/m_ready/s_valid gaps -> identical output sequence to test 3.
//     No beat is lost or duplicated; m_valid/seg_valid are never dropped before their ready.
//  5. reset_n=0 during beat 10 of test 2 -> next cycle all outputs at reset values, cmd_ready=1.
//     A new len=0 command then completes as in test 1.
//  6. len=0xFFFFF, addr=0 -> 4096 headers, addresses 0x0..0xFFF00 in steps of 0x100, all size=255; last has seg_last=1.
//     131072 beats, no pad.

Source files
------------

// File: rtl/srio_nwrite_segmenter.sv
// srio_nwrite_segmenter
// Splits one write command into SRIO NWRITE segments. Full 256-byte segments
// come first, followed by one final segment rounded up to 8/16/32/64/128/256
// bytes. Each segment is a header followed by its 64-bit data beats. Bytes past
// the end of the command are zeroed, and the segment is padded with all-zero
// beats up to its rounded size.
module srio_nwrite_segmenter #(
    parameter int ADDR_W = 34,
    parameter int DATA_W = 64,
    parameter int LEN_W  = 20
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              seg_valid,
    input  logic              seg_ready,
    output logic [ADDR_W-1:0] seg_addr,
    output logic [7:0]        seg_size,
    output logic              seg_last,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              done
);

    localparam int SEG_W  = LEN_W - 8;
    localparam int NBYTES = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    // Command parameters latched at capture
    logic [SEG_W-1:0]  full_segs_q, full_segs_d;
    logic [5:0]        fin_beats_q, fin_beats_d;
    logic [5:0]        real_fin_q, real_fin_d;
    logic [3:0]        last_bytes_q, last_bytes_d;
    logic [7:0]        fin_size_q, fin_size_d;

    // Segment progress
    logic [SEG_W-1:0]  seg_idx_q, seg_idx_d;
    logic [5:0]        load_cnt_q, load_cnt_d;

    // Header output registers
    logic              seg_valid_q, seg_valid_d;
    logic [ADDR_W-1:0] seg_addr_q, seg_addr_d;
    logic [7:0]        seg_size_q, seg_size_d;
    logic              seg_last_q, seg_last_d;

    // Data output stage
    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              m_last_q, m_last_d;

    // Capture-time decode of the command length
    logic [5:0]        cap_fin_beats;
    logic [8:0]        cap_fin_bytes_m1;
    logic [7:0]        cap_fin_size;
    logic              cap_single_seg;

    // Per-segment derived values
    logic [5:0]        seg_beats;
    logic [5:0]        real_beats;
    logic              slot_free;
    logic              last_real_beat;
    logic [SEG_W-1:0]  seg_idx_inc;
    logic [DATA_W-1:0] s_data_masked;

    // Round the final-segment length up to the next supported power of two (in beats)
    always_comb begin
        cap_fin_beats = 6'd32;
        if (cmd_len[7:3] == 5'd0) begin
            cap_fin_beats = 6'd1;
        end else if (cmd_len[7:3] < 5'd2) begin
            cap_fin_beats = 6'd2;
        end else if (cmd_len[7:3] < 5'd4) begin
            cap_fin_beats = 6'd4;
        end else if (cmd_len[7:3] < 5'd8) begin
            cap_fin_beats = 6'd8;
        end else if (cmd_len[7:3] < 5'd16) begin
            cap_fin_beats = 6'd16;
        end
    end

    assign cap_fin_bytes_m1 = {cap_fin_beats, 3'b000} - 9'd1;
    assign cap_fin_size     = cap_fin_bytes_m1[7:0];
    assign cap_single_seg   = (cmd_len[LEN_W-1:8] == '0);

    assign seg_beats      = seg_last_q ? fin_beats_q : 6'd32;
    assign real_beats     = seg_last_q ? real_fin_q : 6'd32;
    assign slot_free      = !m_valid_q || m_ready;
    assign last_real_beat = seg_last_q && (load_cnt_q == (real_fin_q - 6'd1));
    assign seg_idx_inc    = seg_idx_q + SEG_W'(1);

    // Byte 0 is the most significant byte; in the last real beat of the
    // command only the first last_bytes bytes carry payload.
    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_byte_mask
            logic keep;
            assign keep = !last_real_beat || (4'(gi) < last_bytes_q);
            assign s_data_masked[DATA_W-1-8*gi -: 8] = s_data[DATA_W-1-8*gi -: 8] & {8{keep}};
        end
    endgenerate

    // Next-state, header and data-stage logic
    always_comb begin
        state_d      = state_q;
        full_segs_d  = full_segs_q;
        fin_beats_d  = fin_beats_q;
        real_fin_d   = real_fin_q;
        last_bytes_d = last_bytes_q;
        fin_size_d   = fin_size_q;
        seg_idx_d    = seg_idx_q;
        load_cnt_d   = load_cnt_q;
        seg_valid_d  = seg_valid_q;
        seg_addr_d   = seg_addr_q;
        seg_size_d   = seg_size_q;
        seg_last_d   = seg_last_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        m_last_d     = m_last_q;
        s_ready      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    full_segs_d  = cmd_len[LEN_W-1:8];
                    fin_beats_d  = cap_fin_beats;
                    real_fin_d   = {1'b0, cmd_len[7:3]} + 6'd1;
                    last_bytes_d = {1'b0, cmd_len[2:0]} + 4'd1;
                    fin_size_d   = cap_fin_size;
                    seg_idx_d    = '0;
                    seg_valid_d  = 1'b1;
                    seg_addr_d   = cmd_addr;
                    seg_last_d   = cap_single_seg;
                    seg_size_d   = cap_single_seg ? cap_fin_size : 8'hFF;
                    state_d      = ST_HDR;
                end
            end

            ST_HDR: begin
                if (seg_ready) begin
                    seg_valid_d = 1'b0;
                    load_cnt_d  = '0;
                    state_d     = ST_DATA;
                end
            end

            ST_DATA: begin
                // The current beat leaves; a new one may replace it in the same cycle.
                if (m_valid_q && m_ready) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                end
                if ((load_cnt_q < seg_beats) && slot_free) begin
                    if (load_cnt_q < real_beats) begin
                        s_ready = 1'b1;
                        if (s_valid) begin
                            m_valid_d  = 1'b1;
                            m_data_d   = s_data_masked;
                            m_last_d   = (load_cnt_q == (seg_beats - 6'd1));
                            load_cnt_d = load_cnt_q + 6'd1;
                        end
                    end else begin
                        // Padding beat, generated without consuming input
                        m_valid_d  = 1'b1;
                        m_data_d   = '0;
                        m_last_d   = (load_cnt_q == (seg_beats - 6'd1));
                        load_cnt_d = load_cnt_q + 6'd1;
                    end
                end
                if (m_valid_q && m_ready && m_last_q) begin
                    if (seg_last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        seg_idx_d   = seg_idx_inc;
                        seg_valid_d = 1'b1;
                        seg_addr_d  = seg_addr_q + ADDR_W'(256);
                        seg_last_d  = (seg_idx_inc == full_segs_q);
                        seg_size_d  = (seg_idx_inc == full_segs_q) ? fin_size_q : 8'hFF;
                        state_d     = ST_HDR;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            full_segs_q  <= '0;
            fin_beats_q  <= '0;
            real_fin_q   <= '0;
            last_bytes_q <= '0;
            fin_size_q   <= '0;
            seg_idx_q    <= '0;
            load_cnt_q   <= '0;
            seg_valid_q  <= 1'b0;
            seg_addr_q   <= '0;
            seg_size_q   <= '0;
            seg_last_q   <= 1'b0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_last_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            full_segs_q  <= full_segs_d;
            fin_beats_q  <= fin_beats_d;
            real_fin_q   <= real_fin_d;
            last_bytes_q <= last_bytes_d;
            fin_size_q   <= fin_size_d;
            seg_idx_q    <= seg_idx_d;
            load_cnt_q   <= load_cnt_d;
            seg_valid_q  <= seg_valid_d;
            seg_addr_q   <= seg_addr_d;
            seg_size_q   <= seg_size_d;
            seg_last_q   <= seg_last_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_last_q     <= m_last_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign seg_valid = seg_valid_q;
    assign seg_addr  = seg_addr_q;
    assign seg_size  = seg_size_q;
    assign seg_last  = seg_last_q;
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_last    = m_last_q;

endmodule

// File: tb/tb_srio_nwrite_segmenter.sv
// Directed bench for srio_nwrite_segmenter: runs commands, records every
// header and data handshake, and compares them against an expected sequence
// built from byte positions within the command plus hand-computed literals.
module tb_srio_nwrite_segmenter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [19:0] cmd_len;
    logic [33:0] cmd_addr;
    logic [63:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        seg_valid;
    logic        seg_ready;
    logic [33:0] seg_addr;
    logic [7:0]  seg_size;
    logic        seg_last;
    logic [63:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic        done;

    always #5 clk = ~clk;

    srio_nwrite_segmenter #(
        .ADDR_W(34),
        .DATA_W(64),
        .LEN_W (20)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_len  (cmd_len),
        .cmd_addr (cmd_addr),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .seg_valid(seg_valid),
        .seg_ready(seg_ready),
        .seg_addr (seg_addr),
        .seg_size (seg_size),
        .seg_last (seg_last),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_last   (m_last),
        .done     (done)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [33:0] got_haddr[$];
    logic [7:0]  got_hsize[$];
    bit          got_hlast[$];
    logic [63:0] got_data[$];
    bit          got_mlast[$];
    logic [33:0] exp_haddr[$];
    logic [7:0]  exp_hsize[$];
    bit          exp_hlast[$];
    logic [63:0] exp_data[$];
    bit          exp_mlast[$];

    bit use_fixed = 1'b0;
    int src_idx;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] src_beat(input int k);
        logic [7:0] kb;
        kb = 8'(k);
        if (use_fixed) return 64'hAABBCCDD_EEFF0011;
        return {8'h11 ^ kb, 8'h22 ^ kb, 8'h33 ^ kb, 8'h44 ^ kb,
                8'h55 ^ kb, 8'h66 ^ kb, 8'h77 ^ kb, 8'h88 ^ kb};
    endfunction

    // Expected output: segment headers, then each segment's beats where a byte
    // keeps its source value only if its position in the command is <= len.
    task automatic build_expected(input logic [19:0] len, input logic [33:0] addr, input int max_beats);
        int full;
        int bytes;
        int fsz;
        int nb;
        longint k;
        logic [63:0] w;
        logic [63:0] d;
        exp_haddr.delete(); exp_hsize.delete(); exp_hlast.delete();
        exp_data.delete(); exp_mlast.delete();
        full  = int'(len) >> 8;
        bytes = (int'(len) & 255) + 1;
        fsz   = 8;
        while (fsz < bytes) fsz = fsz * 2;
        for (int s = 0; s <= full; s++) begin
            exp_haddr.push_back(34'(longint'(addr) + longint'(s) * 256));
            exp_hsize.push_back((s < full) ? 8'd255 : 8'(fsz - 1));
            exp_hlast.push_back(s == full);
            nb = (s < full) ? 32 : fsz / 8;
            for (int b = 0; b < nb; b++) begin
                if (exp_data.size() < max_beats) begin
                    k = longint'(s) * 32 + b;
                    w = src_beat(int'(k));
                    d = '0;
                    for (int j = 0; j < 8; j++) begin
                        if (k * 8 + j <= longint'(len)) d[63-8*j -: 8] = w[63-8*j -: 8];
                    end
                    exp_data.push_back(d);
                    exp_mlast.push_back(b == nb - 1);
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_s_ready"},   s_ready,   0);
        check({tag, "_seg_valid"}, seg_valid, 0);
        check({tag, "_m_valid"},   m_valid,   0);
        check({tag, "_m_last"},    m_last,    0);
        check({tag, "_seg_last"},  seg_last,  0);
        check({tag, "_done"},      done,      0);
        check({tag, "_seg_addr"},  seg_addr,  0);
        check({tag, "_seg_size"},  seg_size,  0);
        check({tag, "_m_data"},    m_data,    0);
    endtask

    // Run one command; reset_at >= 0 asserts reset once that many beats have been accepted.
    task automatic run_cmd(input string tag, input logic [19:0] len, input logic [33:0] addr,
                           input bit gaps, input int reset_at, input int budget);
        int  cyc;
        int  viol;
        int  n_real;
        bit  finished;
        bit  p_sv, p_sr, p_mv, p_mr;
        logic [33:0] p_sa;
        logic [63:0] p_md;
        got_haddr.delete(); got_hsize.delete(); got_hlast.delete();
        got_data.delete(); got_mlast.delete();
        n_real   = (int'(len) >> 3) + 1;
        src_idx  = 0;
        cyc      = 0;
        viol     = 0;
        finished = 1'b0;
        p_sv = 0; p_sr = 0; p_mv = 0; p_mr = 0; p_sa = '0; p_md = '0;

        @(negedge clk);
        cmd_valid = 1'b1; cmd_len = len; cmd_addr = addr;
        s_valid = 1'b1; s_data = src_beat(0); seg_ready = 1'b1; m_ready = 1'b1;
        #4;
        check({tag, "_cmd_ready"}, cmd_ready, 1);

        while (!finished && cyc < budget) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            cyc++;
            if (reset_at >= 0 && got_data.size() == reset_at) begin
                reset_n = 1'b0; s_valid = 1'b0; seg_ready = 1'b0; m_ready = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
                #4;
                check_reset_outputs({tag, "_rst"});
                finished = 1'b1;
            end else begin
                s_valid   = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                s_data    = (src_idx < n_real) ? src_beat(src_idx) : 64'hDEAD_BEEF_DEAD_BEEF;
                seg_ready = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
                m_ready   = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
                #4;
                if (seg_valid && m_valid) viol++;
                if (p_sv && !p_sr && (!seg_valid || seg_addr !== p_sa)) viol++;
                if (p_mv && !p_mr && (!m_valid || m_data !== p_md)) viol++;
                if (seg_valid && seg_ready) begin
                    got_haddr.push_back(seg_addr);
                    got_hsize.push_back(seg_size);
                    got_hlast.push_back(seg_last);
                    $display("[%0t] %s hdr addr=0x%0h size=%0d last=%0b", $time, tag, seg_addr, seg_size, seg_last);
                end
                if (m_valid && m_ready) begin
                    got_data.push_back(m_data);
                    got_mlast.push_back(m_last);
                    $display("[%0t] %s beat %0d data=0x%016h last=%0b", $time, tag, got_data.size(), m_data, m_last);
                end
                if (s_valid && s_ready) src_idx++;
                if (done) begin
                    finished = 1'b1;
                    $display("[%0t] %s done", $time, tag);
                    check({tag, "_done_after_beats"}, got_data.size(), exp_data.size());
                    check({tag, "_src_accepted"}, src_idx, n_real);
                    @(negedge clk);
                    #4;
                    check({tag, "_done_pulse"}, done, 0);
                    check({tag, "_idle_ready"}, cmd_ready, 1);
                end
                p_sv = seg_valid; p_sr = seg_ready; p_sa = seg_addr;
                p_mv = m_valid;   p_mr = m_ready;   p_md = m_data;
            end
        end
        if (!finished) check({tag, "_timeout"}, 1, 0);
        check({tag, "_protocol"}, viol, 0);
    endtask

    task automatic verify(input string tag, input bit partial);
        int nh;
        int nd;
        if (!partial) begin
            check({tag, "_n_hdr"},  got_haddr.size(), exp_haddr.size());
            check({tag, "_n_beat"}, got_data.size(),  exp_data.size());
        end
        nh = (got_haddr.size() < exp_haddr.size()) ? got_haddr.size() : exp_haddr.size();
        nd = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
        for (int i = 0; i < nh; i++) begin
            check($sformatf("%s_haddr%0d", tag, i), got_haddr[i], exp_haddr[i]);
            check($sformatf("%s_hsize%0d", tag, i), got_hsize[i], exp_hsize[i]);
            check($sformatf("%s_hlast%0d", tag, i), got_hlast[i], exp_hlast[i]);
        end
        for (int i = 0; i < nd; i++) begin
            check($sformatf("%s_data%0d", tag, i),  got_data[i],  exp_data[i]);
            check($sformatf("%s_mlast%0d", tag, i), got_mlast[i], exp_mlast[i]);
        end
    endtask

    task automatic test_single_beat(input string tag);
        use_fixed = 1'b1;
        build_expected(20'd0, 34'h1000, 1 << 30);
        run_cmd(tag, 20'd0, 34'h1000, 1'b0, -1, 500);
        verify(tag, 1'b0);
        if (got_haddr.size() > 0 && got_data.size() > 0) begin
            check({tag, "_lit_addr"}, got_haddr[0], 34'h1000);
            check({tag, "_lit_size"}, got_hsize[0], 8'd7);
            check({tag, "_lit_last"}, got_hlast[0], 1);
            check({tag, "_lit_data"}, got_data[0], 64'hAA00_0000_0000_0000);
            check({tag, "_lit_mlast"}, got_mlast[0], 1);
        end
        use_fixed = 1'b0;
    endtask

    task automatic test_len299(input string tag, input bit gaps);
        logic [63:0] w37;
        w37 = src_beat(37);
        build_expected(20'd299, 34'h2000, 1 << 30);
        run_cmd(tag, 20'd299, 34'h2000, gaps, -1, 3000);
        verify(tag, 1'b0);
        check({tag, "_lit_nbeat"}, got_data.size(), 40);
        if (got_haddr.size() == 2 && got_data.size() == 40) begin
            check({tag, "_lit_h0"}, {got_haddr[0], got_hsize[0], 7'd0, got_hlast[0]}, {34'h2000, 8'd255, 8'd0});
            check({tag, "_lit_h1"}, {got_haddr[1], got_hsize[1], 7'd0, got_hlast[1]}, {34'h2100, 8'd63, 8'd1});
            check({tag, "_lit_b38"}, got_data[37], {w37[63:32], 32'h0});
            check({tag, "_lit_pad1"}, got_data[38], 64'h0);
            check({tag, "_lit_pad2"}, got_data[39], 64'h0);
            check({tag, "_lit_mlast32"}, got_mlast[31], 1);
            check({tag, "_lit_mlast40"}, got_mlast[39], 1);
        end
    endtask

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0; cmd_addr = '0;
        s_data = '0; s_valid = 1'b0; seg_ready = 1'b0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        #4;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // 1: single byte
        test_single_beat("t1");

        // 2: exactly one full segment, no padding
        build_expected(20'd255, 34'h0, 1 << 30);
        run_cmd("t2", 20'd255, 34'h0, 1'b0, -1, 500);
        verify("t2", 1'b0);
        check("t2_lit_nbeat", got_data.size(), 32);
        if (got_haddr.size() == 1) check("t2_lit_size", got_hsize[0], 8'd255);

        // 3/4: one full segment plus a padded 64-byte final segment
        test_len299("t3", 1'b0);
        test_len299("t4", 1'b1);

        // 5: reset during beat 10 of a 256-byte command, then a fresh command
        build_expected(20'd255, 34'h0, 9);
        run_cmd("t5", 20'd255, 34'h0, 1'b0, 9, 500);
        verify("t5", 1'b1);
        check("t5_n_beat", got_data.size(), 9);
        test_single_beat("t5b");

        // 6: maximum length, first three segments then abort by reset
        build_expected(20'hFFFFF, 34'h0, 70);
        run_cmd("t6", 20'hFFFFF, 34'h0, 1'b0, 70, 500);
        verify("t6", 1'b1);
        check("t6_n_hdr", got_haddr.size(), 3);
        if (got_haddr.size() == 3) begin
            check("t6_lit_addr2", got_haddr[2], 34'h200);
            check("t6_lit_last2", got_hlast[2], 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
